// File: rtl/pong_pkg.sv
// Shared constants, responder state encoding and frame-word builder for the
// networked-pong Pmod ADC responder.
package pong_pkg;

  localparam int VAL_W      = 8;
  localparam int ADC_W      = 12;
  localparam int LEAD_ZEROS = 4;
  localparam int FRAME_BITS = LEAD_ZEROS + ADC_W;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } resp_state_e;

  // The paddle value sits MSB-aligned in the conversion field, behind the leading zeros.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [VAL_W-1:0] val);
    return {{LEAD_ZEROS{1'b0}}, val, {(ADC_W-VAL_W){1'b0}}};
  endfunction

endpackage

// File: rtl/pmod_adc_responder_if.sv
// Pmod header pins between an ADC master (the pot reader) and the responder.
// With PMOD_DUAL_CH_EN defined the second data line and its enable are present.
interface pmod_adc_responder_if;

  logic cs_n_in;
  logic sclk_in;
  logic sdata_out;
  logic sdata_oe;
`ifdef PMOD_DUAL_CH_EN
  logic sdata1_out;
  logic sdata1_oe;

  modport master (output cs_n_in, output sclk_in,
                  input sdata_out, input sdata_oe, input sdata1_out, input sdata1_oe);
  modport slave  (input cs_n_in, input sclk_in,
                  output sdata_out, output sdata_oe, output sdata1_out, output sdata1_oe);
`else
  modport master (output cs_n_in, output sclk_in, input sdata_out, input sdata_oe);
  modport slave  (input cs_n_in, input sclk_in, output sdata_out, output sdata_oe);
`endif

endinterface

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous strobe plus a history flop that
// yields single-cycle rise/fall pulses one cycle after the second stage.
module edge_sync (
  input  logic clk,
  input  logic d_in,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Left unreset on purpose: the chain self-flushes within three cycles, and
  // resetting it would fake an edge whenever reset releases with CS_n held low.
  always_ff @(posedge clk) begin
    meta_q <= meta_d;
    sync_q <= sync_d;
    prev_q <= prev_d;
  end

  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/pmod_adc_responder.sv
// Serial responder emulating a Pmod ADC so a remote board's paddle value can be
// read by the unchanged pot reader. Optional macro: PMOD_DUAL_CH_EN (adds value1/sdata1).
module pmod_adc_responder #(
  parameter int VAL_W      = pong_pkg::VAL_W,
  parameter int ADC_W      = pong_pkg::ADC_W,
  parameter int LEAD_ZEROS = pong_pkg::LEAD_ZEROS,
  parameter int FRAME_BITS = pong_pkg::FRAME_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [VAL_W-1:0] value,
`ifdef PMOD_DUAL_CH_EN
  input  logic [VAL_W-1:0] value1,
`endif
  pmod_adc_responder_if.slave pins,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_abort
);

  import pong_pkg::*;

  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  // The frame builder lives in the package, so the geometry must match it.
  if (FRAME_BITS != LEAD_ZEROS + ADC_W || VAL_W != pong_pkg::VAL_W ||
      ADC_W != pong_pkg::ADC_W || LEAD_ZEROS != pong_pkg::LEAD_ZEROS) begin : g_bad_cfg
    $error("pmod_adc_responder: parameters disagree with pong_pkg frame geometry");
  end

  logic cs_rise, cs_fall;
  logic sclk_fall, sclk_rise_unused;

  edge_sync u_cs_sync (
    .clk  (clk),
    .d_in (pins.cs_n_in),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  edge_sync u_sclk_sync (
    .clk  (clk),
    .d_in (pins.sclk_in),
    .rise (sclk_rise_unused),
    .fall (sclk_fall)
  );

  resp_state_e           state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  sdata_q, sdata_d;
  logic                  oe_q, oe_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  abort_q, abort_d;
  logic [FRAME_BITS-1:0] frame_word;

  assign frame_word = build_frame(value);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      sdata_q   <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      sdata_q   <= sdata_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
    end
  end

  // A CS_n rise outranks an SCLK fall seen in the same cycle.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    sdata_d   = sdata_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;

    case (state_q)
      IDLE: begin
        sdata_d = 1'b0;
        oe_d    = 1'b0;
        busy_d  = 1'b0;
        if (cs_fall) begin
          shift_d   = frame_word;
          sdata_d   = frame_word[FRAME_BITS-1];
          oe_d      = 1'b1;
          busy_d    = 1'b1;
          bit_cnt_d = LAST_BIT;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          abort_d   = 1'b1;
          sdata_d   = 1'b0;
          oe_d      = 1'b0;
          busy_d    = 1'b0;
          bit_cnt_d = '0;
          state_d   = IDLE;
        end else if (sclk_fall) begin
          if (bit_cnt_q == '0) begin
            sdata_d = 1'b0;
            oe_d    = 1'b0;
            state_d = DONE;
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
            sdata_d   = shift_q[bit_cnt_d];
          end
        end
      end
      DONE: begin
        sdata_d = 1'b0;
        oe_d    = 1'b0;
        busy_d  = 1'b1;
        if (cs_rise) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        sdata_d   = 1'b0;
        oe_d      = 1'b0;
        busy_d    = 1'b0;
        bit_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  assign pins.sdata_out = sdata_q;
  assign pins.sdata_oe  = oe_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;
  assign frame_abort    = abort_q;

`ifdef PMOD_DUAL_CH_EN
  logic [FRAME_BITS-1:0] shift1_q, shift1_d;
  logic                  sdata1_q, sdata1_d;
  logic [FRAME_BITS-1:0] frame_word1;

  assign frame_word1 = build_frame(value1);

  always_ff @(posedge clk) begin
    if (reset) begin
      shift1_q <= '0;
      sdata1_q <= 1'b0;
    end else begin
      shift1_q <= shift1_d;
      sdata1_q <= sdata1_d;
    end
  end

  // Second channel rides the first channel's state and bit counter in lockstep.
  always_comb begin
    shift1_d = shift1_q;
    sdata1_d = 1'b0;
    if (state_q == IDLE && state_d == SHIFT) begin
      shift1_d = frame_word1;
      sdata1_d = frame_word1[FRAME_BITS-1];
    end else if (state_q == SHIFT && state_d == SHIFT) begin
      sdata1_d = shift1_q[bit_cnt_d];
    end
  end

  assign pins.sdata1_out = sdata1_q;
  assign pins.sdata1_oe  = oe_q;
`endif

endmodule

// File: tb/tb_pmod_adc_responder.sv
// Self-checking bench for pmod_adc_responder: directed and randomized SPI frames
// checked every cycle against a frame-level model. Honours PMOD_DUAL_CH_EN.
`timescale 1ns/1ps
module tb_pmod_adc_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] value = 8'h00;
`ifdef PMOD_DUAL_CH_EN
  logic [7:0]  value1 = 8'h00;
  int          value1_req = -1;
  logic [15:0] last_rx1;
`endif
  logic busy, frame_done, frame_abort;

  pmod_adc_responder_if pif();

  pmod_adc_responder dut (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
`ifdef PMOD_DUAL_CH_EN
    .value1      (value1),
`endif
    .pins        (pif),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_abort (frame_abort)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  // Frame-level reference: pins are seen two samples late, a frame is a count of
  // SCLK falls into a 16-bit word equal to value*16.
  logic [3:0] cs_hist = 4'hF;
  logic [3:0] sc_hist = 4'hF;
  bit         m_valid = 0;
  bit         m_active = 0;
  int         m_falls = 0;
  int         m_word = 0;
  int         m_word1 = 0;
  bit         e_sdata, e_sdata1, e_oe, e_busy, e_done, e_abort;

  always @(posedge clk) begin
    bit cs_fell, cs_rose, sc_fell;
    cs_hist = {cs_hist[2:0], pif.cs_n_in};
    sc_hist = {sc_hist[2:0], pif.sclk_in};
    cs_fell = cs_hist[3] & ~cs_hist[2];
    cs_rose = ~cs_hist[3] & cs_hist[2];
    sc_fell = sc_hist[3] & ~sc_hist[2];
    e_done  = 0;
    e_abort = 0;
    if (reset) begin
      m_valid  = 1;
      m_active = 0;
      m_falls  = 0;
    end else if (!m_active) begin
      if (cs_fell) begin
        m_active = 1;
        m_falls  = 0;
        m_word   = value * 16;
`ifdef PMOD_DUAL_CH_EN
        m_word1  = value1 * 16;
`endif
      end
    end else if (cs_rose) begin
      if (m_falls < 16) e_abort = 1;
      else e_done = 1;
      m_active = 0;
    end else if (sc_fell && m_falls < 16) begin
      m_falls++;
    end
    e_busy   = m_active;
    e_oe     = m_active && (m_falls < 16);
    e_sdata  = 0;
    e_sdata1 = 0;
    if (e_oe) begin
      e_sdata  = m_word[15 - m_falls];
      e_sdata1 = m_word1[15 - m_falls];
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("cyc_sdata_out", pif.sdata_out, e_sdata);
      checkOutput("cyc_sdata_oe", pif.sdata_oe, e_oe);
      checkOutput("cyc_busy", busy, e_busy);
      checkOutput("cyc_frame_done", frame_done, e_done);
      checkOutput("cyc_frame_abort", frame_abort, e_abort);
`ifdef PMOD_DUAL_CH_EN
      checkOutput("cyc_sdata1_out", pif.sdata1_out, e_sdata1);
      checkOutput("cyc_sdata1_oe", pif.sdata1_oe, e_oe);
`endif
      if (frame_done) done_cnt++;
      if (frame_abort) abort_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One master transaction; data is sampled at the end of each SCLK high phase.
  task automatic applyStimulus(input logic [7:0] v, input int half, input int abort_after,
                               input int change_at, input logic [7:0] change_val,
                               input int reset_at, input bit early_fall, input bit late_fall,
                               output logic [15:0] rx);
    int  done0, abort0, falls;
    bit  reset_hit;
    done0     = done_cnt;
    abort0    = abort_cnt;
    falls     = 0;
    reset_hit = 0;
    rx        = '0;
    value     = v;
`ifdef PMOD_DUAL_CH_EN
    value1    = (value1_req >= 0) ? 8'(value1_req) : 8'($urandom);
    last_rx1  = '0;
`endif
    pif.cs_n_in = 1'b0;
    if (early_fall) begin
      pif.sclk_in = 1'b0;
      tick(half);
      pif.sclk_in = 1'b1;
    end
    tick(half);
    for (int i = 0; i < 16; i++) begin
      if (i == abort_after) break;
      if (i == change_at) value = change_val;
      if (i == reset_at) begin
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        reset_hit = 1;
        checkOutput("reset_mid_sdata_oe", pif.sdata_oe, 0);
        checkOutput("reset_mid_sdata_out", pif.sdata_out, 0);
        checkOutput("reset_mid_busy", busy, 0);
      end
      rx[15-i] = pif.sdata_out;
`ifdef PMOD_DUAL_CH_EN
      last_rx1[15-i] = pif.sdata1_out;
`endif
      pif.sclk_in = 1'b0;
      tick(half);
      pif.sclk_in = 1'b1;
      tick(half);
      falls++;
    end
    if (falls == 16 && !reset_hit) begin
      checkOutput("oe_after_16th_fall", pif.sdata_oe, 0);
      checkOutput("busy_in_done", busy, 1);
`ifdef PMOD_DUAL_CH_EN
      checkOutput("ch1_word", last_rx1, {4'h0, value1, 4'h0});
`endif
    end
    if (late_fall) pif.sclk_in = 1'b0;
    pif.cs_n_in = 1'b1;
    tick(4);
    if (reset_hit) begin
      checkOutput("reset_no_done", done_cnt, done0);
      checkOutput("reset_no_abort", abort_cnt, abort0);
    end else if (falls < 16) begin
      checkOutput("abort_pulse", abort_cnt, abort0 + 1);
      checkOutput("abort_no_done", done_cnt, done0);
    end else begin
      checkOutput("done_pulse", done_cnt, done0 + 1);
      checkOutput("done_no_abort", abort_cnt, abort0);
    end
    checkOutput("end_busy_low", busy, 0);
    checkOutput("end_oe_low", pif.sdata_oe, 0);
    pif.sclk_in = 1'b1;
    tick(half + 2);
  endtask

  task automatic idleNoise(input int half);
    int done0, abort0;
    done0  = done_cnt;
    abort0 = abort_cnt;
    for (int i = 0; i < 20; i++) begin
      pif.sclk_in = ~pif.sclk_in;
      tick(half);
    end
    tick(4);
    checkOutput("noise_no_done", done_cnt, done0);
    checkOutput("noise_no_abort", abort_cnt, abort0);
    checkOutput("noise_oe_low", pif.sdata_oe, 0);
  endtask

  initial begin
    logic [15:0] rx;
    logic [7:0]  v;
    int          kind;
    pif.cs_n_in = 1'b1;
    pif.sclk_in = 1'b1;
    reset = 1'b1;
    tick(5);
    checkOutput("rst_sdata_out", pif.sdata_out, 0);
    checkOutput("rst_sdata_oe", pif.sdata_oe, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_frame_abort", frame_abort, 0);
    reset = 1'b0;
    tick(3);

    $display("[TB] normal frame");
    applyStimulus(8'hA5, 4, 16, 99, 8'h00, 99, 0, 0, rx);
    checkOutput("normal_word", rx, 16'h0A50);

    $display("[TB] snapshot");
    applyStimulus(8'h3C, 4, 16, 10, 8'hFF, 99, 0, 0, rx);
    checkOutput("snapshot_word", rx, 16'h03C0);
    applyStimulus(8'hFF, 4, 16, 99, 8'h00, 99, 0, 0, rx);
    checkOutput("snapshot_next_word", rx, 16'h0FF0);

    $display("[TB] abort");
    applyStimulus(8'h77, 4, 7, 99, 8'h00, 99, 0, 0, rx);
    applyStimulus(8'h01, 4, 16, 99, 8'h00, 99, 0, 0, rx);
    checkOutput("post_abort_word", rx, 16'h0010);

    $display("[TB] idle noise");
    idleNoise(4);

    $display("[TB] reset mid-frame");
    applyStimulus(8'h5A, 4, 16, 99, 8'h00, 9, 0, 0, rx);
    applyStimulus(8'hFF, 4, 16, 99, 8'h00, 99, 0, 0, rx);
    checkOutput("post_reset_word", rx, 16'h0FF0);

    $display("[TB] simultaneous edges");
    applyStimulus(8'hC3, 4, 16, 99, 8'h00, 99, 1, 0, rx);
    checkOutput("cs_fall_sclk_fall_word", rx, 16'h0C30);
    applyStimulus(8'h66, 5, 5, 99, 8'h00, 99, 0, 1, rx);

`ifdef PMOD_DUAL_CH_EN
    $display("[TB] dual-channel round trip");
    value1_req = 17;
    applyStimulus(8'd200, 4, 16, 99, 8'h00, 99, 0, 0, rx);
    checkOutput("rt_ch0_value", rx[11:4], 200);
    checkOutput("rt_ch1_value", last_rx1[11:4], 17);
    value1_req = -1;
`endif

    $display("[TB] randomized frames");
    for (int n = 0; n < 40; n++) begin
      v    = 8'($urandom);
      kind = $urandom_range(0, 9);
      if (kind <= 6) begin
        applyStimulus(v, $urandom_range(4, 6), 16, $urandom_range(1, 20), 8'($urandom),
                      99, 0, 0, rx);
        checkOutput("rand_word", rx, {4'h0, v, 4'h0});
      end else if (kind == 7) begin
        applyStimulus(v, $urandom_range(4, 6), $urandom_range(1, 15), 99, 8'h00,
                      99, 0, $urandom_range(0, 1), rx);
      end else if (kind == 8) begin
        idleNoise($urandom_range(4, 6));
      end else begin
        applyStimulus(v, $urandom_range(4, 6), 16, 99, 8'h00, 99, 1, $urandom_range(0, 1), rx);
        checkOutput("rand_early_word", rx, {4'h0, v, 4'h0});
      end
      tick($urandom_range(0, 5));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pmod_adc_responder.md
Name: pmod_adc_responder

Overview:
- Serial responder that emulates the Pmod ADC a paddle potentiometer normally sits behind.
- A remote board drives its local paddle value out over a Pmod header. The existing potentiometer reader on the receiving board then decodes it unchanged, which enables two-board networked pong.
- Sits between the local paddle-position register and the JA/JB header pins.
- Asynchronous master strobes (CS_n, SCLK) are oversampled on the system clock.

Parameters:
- VAL_W, 8: width of the paddle value input.
- ADC_W, 12: width of the emulated conversion field; value is MSB-aligned, low ADC_W-VAL_W bits are zero.
- LEAD_ZEROS, 4: leading zero bits per frame.
- FRAME_BITS, 16: total bits per frame; must equal LEAD_ZEROS+ADC_W.

Ports:
- clk, input, 1: system clock; must be at least 8x the master SCLK frequency.
- reset, input, 1: synchronous, active-high reset.
- value, input, VAL_W: paddle value; snapshotted at CS_n fall.
- cs_n_in, input, 1: chip select from master (async, active-low).
- sclk_in, input, 1: serial clock from master (async, idles high).
- sdata_out, output, 1: serial data to master.
- sdata_oe, output, 1: tristate enable for the sdata pin; 1 = drive.
- busy, output, 1: high while a frame is in progress.
- frame_done, output, 1: 1-cycle pulse when a complete frame ends.
- frame_abort, output, 1: 1-cycle pulse when CS_n rises mid-frame.

Behaviour:
- Input sampling: cs_n_in and sclk_in each pass through a 2-flop synchronizer plus a registered previous value for edge detection.
  - Edges are detected one cycle after the second flop.
  - All outputs are registered. A pin edge reaches sdata_out 3 clk cycles later.
- Reset values: sdata_out=0, sdata_oe=0, busy=0, frame_done=0, frame_abort=0, state=IDLE, bit_cnt=0, shift reg=0.
- Frame word: {LEAD_ZEROS zeros, value, (ADC_W-VAL_W) zeros}, sent MSB first. For value=8'hA5 the word is 16'h0A50.
- IDLE:
  - sdata_oe=0, sdata_out=0.
  - SCLK edges are ignored.
  - On CS_n fall: latch the frame word, drive bit FRAME_BITS-1 (0), sdata_oe=1, busy=1, bit_cnt=FRAME_BITS-1, go to SHIFT.
- SHIFT:
  - On each SCLK falling edge, decrement bit_cnt and drive word[bit_cnt]. SCLK rising edges change nothing.
  - When the SCLK fall arrives with bit_cnt=0 (the 16th fall), go to DONE with sdata_oe=0 and sdata_out=0.
- DONE:
  - Hold sdata_oe=0 and busy=1.
  - Further SCLK edges are ignored.
  - On CS_n rise: pulse frame_done, busy=0, go to IDLE.
- CS_n rise in SHIFT: pulse frame_abort, sdata_oe=0, busy=0, go to IDLE. No frame_done.
- Simultaneous CS_n rise and SCLK fall detected in the same cycle: the CS_n rise wins and the SCLK edge is discarded.
- CS_n fall and SCLK fall in the same cycle from IDLE: the frame starts and the SCLK edge is discarded.
- value changes during a frame have no effect; the next frame picks them up.
- reset mid-frame: return to IDLE next cycle with all outputs at reset values and no pulses.
- bit_cnt is $clog2(FRAME_BITS) bits wide and never wraps; the transition to DONE happens at 0.

Optional Feature:
- PMOD_DUAL_CH_EN defined: adds input value1 (VAL_W) and outputs sdata1_out/sdata1_oe. These form a second channel framed identically and in lockstep on the same CS_n/SCLK, emulating the dual-channel Pmod ADC so both paddles share one header.
- Undefined: single channel only; those ports do not exist.

Decomposition:
- Package pong_pkg holds:
  - ADC_W, LEAD_ZEROS, FRAME_BITS constants;
  - the responder state enum (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10);
  - a function building the frame word from value.
- Sub-module edge_sync (2-flop sync + rise/fall pulse outputs) is instantiated once each for cs_n_in and sclk_in.

Test Plan:
- Normal frame: value=8'hA5, master SCLK=clk/8, 16 SCLK cycles. Required:
  - bits sampled on SCLK rise = 0000_1010_0101_0000;
  - frame_done pulses once after the CS_n rise;
  - sdata_oe low after the 16th fall.
- Snapshot: value=8'h3C at CS_n fall, then changed to 8'hFF at bit 10. Required: received word 16'h03C0; the next frame yields 16'h0FF0.
- Abort: CS_n rises after 7 SCLK falls. Required: frame_abort=1 for one cycle, frame_done=0, sdata_oe=0, busy=0 within 4 clk. A following full frame with value=8'h01 yields 16'h0010.
- Idle noise: 20 SCLK toggles with CS_n high. Required: sdata_oe stays 0 and no pulses occur.
- Reset mid-frame: reset asserted at bit 9 for 1 cycle. Required: all outputs 0 next cycle and no frame_done even when CS_n later rises. The next frame with value=8'hFF yields 16'h0FF0.
- Round trip (plus PMOD_DUAL_CH_EN): the existing potentiometer reader is attached to the responder with value=8'd200 and value1=8'd17. Required: reader outputs 200 and 17 on the respective channels.
